prog_encoder: RTL and testbench

PROG_ENCODER -- requirements
Module: prog_encoder

---
 rtl/prog_encoder.sv | 164 ++++++++++++++++
 tb/tb_prog_encoder.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/prog_encoder.sv
// prog_encoder -- packs decoded instruction fields into 16-bit words and
// streams them into instruction memory at an auto-incrementing pointer.
//
// Ports:
//   clk, reset            rising-edge clock, synchronous active-high reset
//   base_load, base_addr  reload write pointer (bit0 forced 0), clear count/errs
//   in_valid/in_ready     field handshake; in_opcode/in_rx/in_ry/in_imm fields
//   mem_we/mem_addr/mem_wdata  registered write port, one cycle per word
//   word_count            words written since reset/base_load (saturating)
//   err_illegal, err_range     sticky drop flags
//   full                  word at 0xFFFE written; no further writes accepted
module prog_encoder (
  input  logic        clk,
  input  logic        reset,
  input  logic        base_load,
  input  logic [15:0] base_addr,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [4:0]  in_opcode,
  input  logic [2:0]  in_rx,
  input  logic [2:0]  in_ry,
  input  logic [15:0] in_imm,
  output logic        mem_we,
  output logic [15:0] mem_addr,
  output logic [15:0] mem_wdata,
  output logic [15:0] word_count,
  output logic        err_illegal,
  output logic        err_range,
  output logic        full
);

  typedef enum logic [1:0] {S_IDLE, S_EXPAND, S_FULL} state_t;

  localparam logic [4:0]  OP_MVHI = 5'b10110;
  localparam logic [15:0] LAST_ADDR = 16'hFFFE;

  state_t      state_q, state_d;
  logic [15:0] ptr_q, ptr_d;
  logic [15:0] cnt_q, cnt_d;
  logic [15:0] hi_q, hi_d;       // pending mvhi word during EXPAND
  logic        we_q, we_d;
  logic [15:0] addr_q, addr_d;
  logic [15:0] wdata_q, wdata_d;
  logic        ill_q, ill_d;
  logic        rng_q, rng_d;

  // Field decode
  logic        legal, range_ok, expand;
  logic        imm8_ok, imm11_ok;
  logic [15:0] word1, word2;
  logic        wr;
  logic [15:0] wr_word;

  // Sign-extension checks: upper bits must all equal the sign bit.
  assign imm8_ok  = (&in_imm[15:7])  | ~(|in_imm[15:7]);
  assign imm11_ok = (&in_imm[15:10]) | ~(|in_imm[15:10]);
  assign word2    = {in_imm[15:8], in_rx, OP_MVHI};

  always_comb begin
    legal    = 1'b1;
    range_ok = 1'b1;
    expand   = 1'b0;
    word1    = {in_imm[7:0], in_rx, in_opcode};
    case (in_opcode)
      5'b00000, 5'b00001, 5'b00010, 5'b00011, 5'b00100, 5'b00101,
      5'b01000, 5'b01001, 5'b01010, 5'b01100:
        word1 = {5'b0, in_ry, in_rx, in_opcode};
      5'b10000: expand = ~imm8_ok;                 // mvi: never a range error
      5'b10001, 5'b10010, 5'b10011: range_ok = imm8_ok;
      OP_MVHI: range_ok = (in_imm[15:8] == 8'h00);
      5'b11000, 5'b11001, 5'b11010, 5'b11100: begin
        range_ok = imm11_ok;
        word1    = {in_imm[10:0], in_opcode};
      end
      default: legal = 1'b0;
    endcase
  end

  assign in_ready = (state_q == S_IDLE) && !base_load;

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    hi_d    = hi_q;
    we_d    = 1'b0;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    ill_d   = ill_q;
    rng_d   = rng_q;
    wr      = 1'b0;
    wr_word = word1;
    if (base_load) begin
      // Also aborts a pending expansion word.
      state_d = S_IDLE;
      ptr_d   = {base_addr[15:1], 1'b0};
      cnt_d   = 16'h0;
      ill_d   = 1'b0;
      rng_d   = 1'b0;
    end else begin
      case (state_q)
        S_IDLE: if (in_valid) begin
          if (!legal)         ill_d = 1'b1;
          else if (!range_ok) rng_d = 1'b1;
          else begin
            wr = 1'b1;
            // At the last address the expansion word is discarded.
            if (ptr_q == LAST_ADDR) state_d = S_FULL;
            else if (expand) begin
              state_d = S_EXPAND;
              hi_d    = word2;
            end
          end
        end
        S_EXPAND: begin
          wr      = 1'b1;
          wr_word = hi_q;
          state_d = (ptr_q == LAST_ADDR) ? S_FULL : S_IDLE;
        end
        default: ;
      endcase
      if (wr) begin
        we_d    = 1'b1;
        addr_d  = ptr_q;
        wdata_d = wr_word;
        ptr_d   = ptr_q + 16'd2;
        cnt_d   = (cnt_q == 16'hFFFF) ? cnt_q : cnt_q + 16'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      ptr_q   <= 16'h0;
      cnt_q   <= 16'h0;
      hi_q    <= 16'h0;
      we_q    <= 1'b0;
      addr_q  <= 16'h0;
      wdata_q <= 16'h0;
      ill_q   <= 1'b0;
      rng_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      hi_q    <= hi_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      ill_q   <= ill_d;
      rng_q   <= rng_d;
    end
  end

  assign mem_we      = we_q;
  assign mem_addr    = addr_q;
  assign mem_wdata   = wdata_q;
  assign word_count  = cnt_q;
  assign err_illegal = ill_q;
  assign err_range   = rng_q;
  assign full        = (state_q == S_FULL);

endmodule

// File: tb/tb_prog_encoder.sv
// Bench for prog_encoder: queue-based reference model checked every cycle,
// plus directed scenarios with hand-computed literal expectations.
module tb_prog_encoder;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        base_load = 1'b0;
  logic [15:0] base_addr = '0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [4:0]  in_opcode = '0;
  logic [2:0]  in_rx = '0;
  logic [2:0]  in_ry = '0;
  logic [15:0] in_imm = '0;
  logic        mem_we;
  logic [15:0] mem_addr, mem_wdata, word_count;
  logic        err_illegal, err_range, full;

  int n_chk = 0;
  int n_pass = 0;

  prog_encoder dut (
    .clk(clk), .reset(reset), .base_load(base_load), .base_addr(base_addr),
    .in_valid(in_valid), .in_ready(in_ready), .in_opcode(in_opcode),
    .in_rx(in_rx), .in_ry(in_ry), .in_imm(in_imm), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .word_count(word_count),
    .err_illegal(err_illegal), .err_range(err_range), .full(full)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  // ---------------- reference model ----------------
  // Pending words live in a queue; one word leaves per cycle.
  logic [15:0] m_q[$];
  logic [15:0] m_ptr, m_cnt, m_addr, m_wdata;
  logic        m_we, m_full, m_ill, m_rng;
  bit          chk_en = 0;

  task automatic model_accept();
    int s;
    int op;
    s  = int'($signed(in_imm));
    op = int'(in_opcode);
    if (op inside {[0:5], 8, 9, 10, 12})
      m_q.push_back({5'b0, in_ry, in_rx, in_opcode});
    else if (op == 16) begin
      m_q.push_back({in_imm[7:0], in_rx, in_opcode});
      if (s < -128 || s > 127) m_q.push_back({in_imm[15:8], in_rx, 5'b10110});
    end else if (op inside {17, 18, 19}) begin
      if (s < -128 || s > 127) m_rng = 1;
      else m_q.push_back({in_imm[7:0], in_rx, in_opcode});
    end else if (op == 22) begin
      if (in_imm > 16'd255) m_rng = 1;
      else m_q.push_back({in_imm[7:0], in_rx, in_opcode});
    end else if (op inside {24, 25, 26, 28}) begin
      if (s < -1024 || s > 1023) m_rng = 1;
      else m_q.push_back({in_imm[10:0], in_opcode});
    end else m_ill = 1;
  endtask

  // Compare current outputs, then advance the model with the inputs that
  // the next rising edge will sample (inputs change only just after posedge).
  initial begin
    forever begin
      @(negedge clk);
      if (chk_en) begin
        chk("mem_we", {15'b0, mem_we}, {15'b0, m_we});
        chk("mem_addr", mem_addr, m_addr);
        chk("mem_wdata", mem_wdata, m_wdata);
        chk("word_count", word_count, m_cnt);
        chk("err_illegal", {15'b0, err_illegal}, {15'b0, m_ill});
        chk("err_range", {15'b0, err_range}, {15'b0, m_rng});
        chk("full", {15'b0, full}, {15'b0, m_full});
        chk("in_ready", {15'b0, in_ready},
            {15'b0, !m_full && m_q.size() == 0 && !base_load});
      end
      if (reset) begin
        m_q.delete(); m_ptr = 0; m_cnt = 0; m_addr = 0; m_wdata = 0;
        m_we = 0; m_full = 0; m_ill = 0; m_rng = 0;
        chk_en = 1;
      end else begin
        m_we = 0;
        if (base_load) begin
          m_q.delete(); m_ptr = base_addr & 16'hFFFE; m_cnt = 0;
          m_full = 0; m_ill = 0; m_rng = 0;
        end else begin
          if (in_valid && !m_full && m_q.size() == 0) model_accept();
          if (m_q.size() > 0) begin
            m_we = 1; m_addr = m_ptr; m_wdata = m_q.pop_front();
            if (m_cnt != 16'hFFFF) m_cnt = m_cnt + 1;
            if (m_ptr == 16'hFFFE) begin m_full = 1; m_q.delete(); end
            m_ptr = m_ptr + 2;
          end
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic cyc(input logic v, input logic [4:0] op, input logic [2:0] rx,
                     input logic [2:0] ry, input logic [15:0] imm,
                     input logic bl, input logic [15:0] ba);
    in_valid = v; in_opcode = op; in_rx = rx; in_ry = ry; in_imm = imm;
    base_load = bl; base_addr = ba;
    @(posedge clk); #1;
    in_valid = 0; base_load = 0;
  endtask

  task automatic send(input logic [4:0] op, input logic [2:0] rx,
                      input logic [2:0] ry, input logic [15:0] imm);
    cyc(1'b1, op, rx, ry, imm, 1'b0, 16'h0);
  endtask

  task automatic idle();
    cyc(1'b0, 5'd0, 3'd0, 3'd0, 16'h0, 1'b0, 16'h0);
  endtask

  task automatic bload(input logic [15:0] ba);
    cyc(1'b0, 5'd0, 3'd0, 3'd0, 16'h0, 1'b1, ba);
  endtask

  task automatic do_reset();
    reset = 1; in_valid = 0; base_load = 0;
    @(posedge clk); #1;
    reset = 0;
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1 reset = 0;
    chk("rst in_ready", {15'b0, in_ready}, 16'h1);
    chk("rst mem_we", {15'b0, mem_we}, 16'h0);
    chk("rst word_count", word_count, 16'h0);

    // add r2,r3
    send(5'b00001, 3'd2, 3'd3, 16'h0);
    chk("add we", {15'b0, mem_we}, 16'h1);
    chk("add addr", mem_addr, 16'h0000);
    chk("add data", mem_wdata, 16'h0341);
    chk("add count", word_count, 16'h1);

    // mvi r1,0x1234 expands into mvi + mvhi
    do_reset();
    send(5'b10000, 3'd1, 3'd0, 16'h1234);
    chk("mvi w1 data", mem_wdata, 16'h3430);
    chk("mvi w1 addr", mem_addr, 16'h0000);
    chk("mvi expand rdy", {15'b0, in_ready}, 16'h0);
    send(5'b00001, 3'd2, 3'd3, 16'h0);   // offered during EXPAND: ignored
    chk("mvi w2 data", mem_wdata, 16'h1236);
    chk("mvi w2 addr", mem_addr, 16'h0002);
    chk("mvi count", word_count, 16'h2);
    idle();
    chk("ignored no we", {15'b0, mem_we}, 16'h0);

    // illegal opcode then out-of-range addi
    do_reset();
    send(5'b00110, 3'd0, 3'd0, 16'h0);
    send(5'b10001, 3'd0, 3'd0, 16'd200);
    chk("drop no we", {15'b0, mem_we}, 16'h0);
    chk("err_illegal", {15'b0, err_illegal}, 16'h1);
    chk("err_range", {15'b0, err_range}, 16'h1);
    send(5'b00001, 3'd2, 3'd3, 16'h0);
    chk("ptr unchanged", mem_addr, 16'h0000);
    chk("errs sticky", {14'b0, err_illegal, err_range}, 16'h3);

    // fill to the top of memory with jz -1
    bload(16'hFFFD);
    chk("bl clears errs", {14'b0, err_illegal, err_range}, 16'h0);
    send(5'b11001, 3'd0, 3'd0, 16'hFFFF);
    chk("jz data", mem_wdata, 16'hFFF9);
    chk("jz addr1", mem_addr, 16'hFFFC);
    chk("jz not full", {15'b0, full}, 16'h0);
    send(5'b11001, 3'd0, 3'd0, 16'hFFFF);
    chk("jz addr2", mem_addr, 16'hFFFE);
    chk("full", {15'b0, full}, 16'h1);
    chk("full rdy", {15'b0, in_ready}, 16'h0);
    send(5'b00001, 3'd1, 3'd1, 16'h0);
    chk("full no we", {15'b0, mem_we}, 16'h0);
    bload(16'h0010);
    chk("bl clears full", {15'b0, full}, 16'h0);

    // base_load beats in_valid; base_load aborts EXPAND
    cyc(1'b1, 5'b00001, 3'd1, 3'd1, 16'h0, 1'b1, 16'h0100);
    chk("bl+valid no we", {15'b0, mem_we}, 16'h0);
    send(5'b10000, 3'd1, 3'd0, 16'h1234);
    chk("bl mvi addr", mem_addr, 16'h0100);
    bload(16'h0200);
    chk("abort no we", {15'b0, mem_we}, 16'h0);
    chk("abort count", word_count, 16'h0);
    send(5'b00001, 3'd2, 3'd3, 16'h0);
    chk("after abort addr", mem_addr, 16'h0200);

    // expanding mvi at the last address writes word1 only
    bload(16'hFFFE);
    send(5'b10000, 3'd1, 3'd0, 16'h1234);
    chk("last mvi data", mem_wdata, 16'h3430);
    chk("last mvi full", {15'b0, full}, 16'h1);
    idle();
    chk("last no w2", {15'b0, mem_we}, 16'h0);
    chk("last count", word_count, 16'h1);

    // range boundaries
    do_reset();
    send(5'b10000, 3'd0, 3'd0, 16'hFFFB);      // mvi -5: single word
    chk("mvi small", mem_wdata, 16'hFB10);
    chk("mvi small rdy", {15'b0, in_ready}, 16'h1);
    send(5'b11000, 3'd0, 3'd0, 16'd1024);
    chk("j 1024 drop", {15'b0, err_range}, 16'h1);
    send(5'b11000, 3'd0, 3'd0, 16'hFC00);      // -1024
    chk("j -1024", mem_wdata, 16'h8018);
    send(5'b10110, 3'd3, 3'd0, 16'h0100);
    chk("mvhi drop", {15'b0, mem_we}, 16'h0);
    send(5'b10110, 3'd3, 3'd0, 16'h00AB);
    chk("mvhi ok", mem_wdata, 16'hAB76);
    send(5'b10010, 3'd2, 3'd0, 16'hFF80);      // subi -128
    chk("subi -128", mem_wdata, 16'h8052);
    send(5'b10011, 3'd0, 3'd0, 16'hFF7F);      // cmpi -129
    chk("cmpi -129 drop", {15'b0, mem_we}, 16'h0);
    send(5'b11100, 3'd0, 3'd0, 16'd1023);
    chk("j 1023", mem_wdata, 16'h7FFC);

    // reset during EXPAND discards word2
    do_reset();
    send(5'b10000, 3'd2, 3'd0, 16'h8000);
    chk("neg mvi w1", mem_wdata, 16'h0050);
    do_reset();
    chk("rst exp no we", {15'b0, mem_we}, 16'h0);
    idle();
    chk("rst exp still none", {15'b0, mem_we}, 16'h0);
    chk("rst exp count", word_count, 16'h0);
    repeat (3) idle();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
